instr_decode: RTL and testbench

Instruction-decode stage of the pipeline: sits directly downstream of instruction fetch and consumes the fetched 32-bit instruction word plus its PC. It owns the 32x32 register file, decodes the MIPS-style instruction into control signals, reads operands with write-back bypass, detects load-use hazards, and registers everything into the ID/EX pipeline register.

---
 rtl/instr_decode.sv | 225 ++++++++++++++++++++++
 tb/tb_instr_decode.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - MIPS-style decode stage with register file, write-back bypass and load-use hazard detection
module instr_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic [31:0] ir_pc,
  input  logic        ir_valid,
  output logic        ir_ready,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        dec_valid,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_rs_val,
  output logic [31:0] dec_rt_val,
  output logic [31:0] dec_imm,
  output logic [4:0]  dec_dest,
  output logic [3:0]  dec_alu_op,
  output logic        dec_reg_write,
  output logic        dec_mem_read,
  output logic        dec_mem_write,
  output logic        dec_branch_eq,
  output logic        dec_branch_ne,
  output logic        dec_jump,
  output logic        dec_illegal
);

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign shamt    = ir[10:6];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign imm_zext = {16'h0000, ir[15:0]};

  logic [31:0] regs [32];

  logic [3:0]  d_alu_op;
  logic [31:0] d_imm;
  logic [4:0]  d_dest;
  logic        d_reg_write;
  logic        d_mem_read;
  logic        d_mem_write;
  logic        d_branch_eq;
  logic        d_branch_ne;
  logic        d_jump;
  logic        d_illegal;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hazard;
  logic        wb_hit;

  // Instruction decode into control fields; anything unrecognised becomes an illegal no-op
  always_comb begin
    d_alu_op    = ALU_ADD;
    d_imm       = 32'h0;
    d_dest      = 5'd0;
    d_reg_write = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_branch_eq = 1'b0;
    d_branch_ne = 1'b0;
    d_jump      = 1'b0;
    d_illegal   = 1'b0;
    case (op)
      6'h00: begin
        d_dest      = rd;
        d_reg_write = 1'b1;
        d_imm       = {27'h0, shamt};
        case (funct)
          6'h20: d_alu_op = ALU_ADD;
          6'h22: d_alu_op = ALU_SUB;
          6'h24: d_alu_op = ALU_AND;
          6'h25: d_alu_op = ALU_OR;
          6'h2A: d_alu_op = ALU_SLT;
          6'h00: d_alu_op = ALU_SLL;
          6'h02: d_alu_op = ALU_SRL;
          default: begin
            d_illegal   = 1'b1;
            d_dest      = 5'd0;
            d_reg_write = 1'b0;
            d_imm       = 32'h0;
          end
        endcase
      end
      6'h08, 6'h09: begin
        d_imm       = imm_sext;
        d_dest      = rt;
        d_reg_write = 1'b1;
      end
      6'h0C: begin
        d_alu_op    = ALU_AND;
        d_imm       = imm_zext;
        d_dest      = rt;
        d_reg_write = 1'b1;
      end
      6'h0D: begin
        d_alu_op    = ALU_OR;
        d_imm       = imm_zext;
        d_dest      = rt;
        d_reg_write = 1'b1;
      end
      6'h23: begin
        d_imm       = imm_sext;
        d_dest      = rt;
        d_reg_write = 1'b1;
        d_mem_read  = 1'b1;
      end
      6'h2B: begin
        d_imm       = imm_sext;
        d_mem_write = 1'b1;
      end
      6'h04: begin
        d_alu_op    = ALU_SUB;
        d_imm       = imm_sext;
        d_branch_eq = 1'b1;
      end
      6'h05: begin
        d_alu_op    = ALU_SUB;
        d_imm       = imm_sext;
        d_branch_ne = 1'b1;
      end
      6'h02: begin
        d_imm  = {ir_pc[31:28], ir[25:0], 2'b00};
        d_jump = 1'b1;
      end
      6'h03: begin
        d_imm       = {ir_pc[31:28], ir[25:0], 2'b00};
        d_jump      = 1'b1;
        d_dest      = 5'd31;
        d_reg_write = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // Operand read with write-back bypass so a same-cycle write is seen by the captured operands
  always_comb begin
    wb_hit = wb_en && (wb_addr != 5'd0);
    if (rs == 5'd0)                rs_val = 32'h0;
    else if (wb_hit && wb_addr == rs) rs_val = wb_data;
    else                           rs_val = regs[rs];
    if (rt == 5'd0)                rt_val = 32'h0;
    else if (wb_hit && wb_addr == rt) rt_val = wb_data;
    else                           rt_val = regs[rt];
  end

  assign hazard   = dec_valid && dec_mem_read && (dec_dest != 5'd0) &&
                    ((dec_dest == rs) || (dec_dest == rt));
  assign ir_ready = !stall && !hazard;

  // Register file: writes proceed independent of pipeline stall/flush; r0 is never written
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // ID/EX register: flush beats stall; hazard or no input yields a bubble with control flags cleared
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_valid     <= 1'b0;
      dec_pc        <= 32'h0;
      dec_rs_val    <= 32'h0;
      dec_rt_val    <= 32'h0;
      dec_imm       <= 32'h0;
      dec_dest      <= 5'd0;
      dec_alu_op    <= 4'd0;
      dec_reg_write <= 1'b0;
      dec_mem_read  <= 1'b0;
      dec_mem_write <= 1'b0;
      dec_branch_eq <= 1'b0;
      dec_branch_ne <= 1'b0;
      dec_jump      <= 1'b0;
      dec_illegal   <= 1'b0;
    end else if (flush || (!stall && (hazard || !ir_valid))) begin
      dec_valid     <= 1'b0;
      dec_reg_write <= 1'b0;
      dec_mem_read  <= 1'b0;
      dec_mem_write <= 1'b0;
      dec_branch_eq <= 1'b0;
      dec_branch_ne <= 1'b0;
      dec_jump      <= 1'b0;
      dec_illegal   <= 1'b0;
    end else if (!stall) begin
      dec_valid     <= 1'b1;
      dec_pc        <= ir_pc;
      dec_rs_val    <= rs_val;
      dec_rt_val    <= rt_val;
      dec_imm       <= d_imm;
      dec_dest      <= d_dest;
      dec_alu_op    <= d_alu_op;
      dec_reg_write <= d_reg_write && (d_dest != 5'd0);
      dec_mem_read  <= d_mem_read;
      dec_mem_write <= d_mem_write;
      dec_branch_eq <= d_branch_eq;
      dec_branch_ne <= d_branch_ne;
      dec_jump      <= d_jump;
      dec_illegal   <= d_illegal;
    end
  end

endmodule

// File: tb/tb_instr_decode.sv
// tb/tb_instr_decode.sv - scoreboard bench for instr_decode
module tb_instr_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_rs_val;
  logic [31:0] dec_rt_val;
  logic [31:0] dec_imm;
  logic [4:0]  dec_dest;
  logic [3:0]  dec_alu_op;
  logic        dec_reg_write;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_branch_eq;
  logic        dec_branch_ne;
  logic        dec_jump;
  logic        dec_illegal;

  instr_decode dut (
    .clk(clk), .reset(reset), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .stall(stall), .flush(flush), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .dec_valid(dec_valid), .dec_pc(dec_pc),
    .dec_rs_val(dec_rs_val), .dec_rt_val(dec_rt_val), .dec_imm(dec_imm),
    .dec_dest(dec_dest), .dec_alu_op(dec_alu_op), .dec_reg_write(dec_reg_write),
    .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dec_branch_eq(dec_branch_eq), .dec_branch_ne(dec_branch_ne),
    .dec_jump(dec_jump), .dec_illegal(dec_illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] F_RW  = 7'b1000000;
  localparam logic [6:0] F_MR  = 7'b0100000;
  localparam logic [6:0] F_MW  = 7'b0010000;
  localparam logic [6:0] F_BEQ = 7'b0001000;
  localparam logic [6:0] F_JMP = 7'b0000010;
  localparam logic [6:0] F_ILL = 7'b0000001;

  typedef logic [143:0] out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  function automatic out_t mk(input logic [31:0] pc, input logic [31:0] rsv,
                              input logic [31:0] rtv, input logic [31:0] imm,
                              input logic [4:0] dest, input logic [3:0] alu,
                              input logic [6:0] flags);
    return {pc, rsv, rtv, imm, dest, alu, flags};
  endfunction

  function automatic out_t cur();
    return {dec_pc, dec_rs_val, dec_rt_val, dec_imm, dec_dest, dec_alu_op,
            dec_reg_write, dec_mem_read, dec_mem_write, dec_branch_eq,
            dec_branch_ne, dec_jump, dec_illegal};
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input out_t exp);
    ir       = instr;
    ir_pc    = pc;
    ir_valid = 1'b1;
    exp_q.push_back(exp);
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wb_en   = en;
    wb_addr = addr;
    wb_data = data;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    out_t last_exp = '0;
    bit   have_last = 1'b0;

    reset = 1'b1; ir = 32'h0; ir_pc = 32'h0; ir_valid = 1'b0;
    stall = 1'b0; flush = 1'b0;
    wb(1'b0, 5'd0, 32'h0);

    // monitor: pops an expectation for each newly captured output, checks held outputs under stall
    fork
      forever begin
        bit ps;
        out_t e;
        @(posedge clk);
        ps = stall;
        @(negedge clk);
        if (dec_valid) begin
          if (ps) begin
            if (have_last) check("held_outputs", cur(), last_exp);
          end else if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_output: got %h expected no valid output", cur());
          end else begin
            e = exp_q.pop_front();
            check($sformatf("out_pc_%h", e[143:112]), cur(), e);
            last_exp  = e;
            have_last = 1'b1;
          end
        end
      end
    join_none

    step();
    step();
    check("reset_dec_valid", {143'h0, dec_valid}, '0);
    check("reset_outputs", cur(), '0);
    check("reset_ir_ready", {143'h0, ir_ready}, {143'h0, 1'b1});
    reset = 1'b0;

    wb(1'b1, 5'd5, 32'h0000_1234); step();
    wb(1'b1, 5'd6, 32'hFFFF_0000); step();
    wb(1'b0, 5'd0, 32'h0);

    // add r7,r5,r6
    issue(32'h00A63820, 32'h100, mk(32'h100, 32'h1234, 32'hFFFF0000, 32'h0, 5'd7, 4'd0, F_RW));
    step();
    // addi r1,r0,-1 while write-back targets r0
    wb(1'b1, 5'd0, 32'h5);
    issue(32'h2001FFFF, 32'h104, mk(32'h104, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd1, 4'd0, F_RW));
    step();
    wb(1'b0, 5'd0, 32'h0);
    // ori r1,r0,0x8000
    issue(32'h34018000, 32'h108, mk(32'h108, 32'h0, 32'h0, 32'h00008000, 5'd1, 4'd3, F_RW));
    step();
    // add r8,r3,r5 with r3 written the same cycle
    wb(1'b1, 5'd3, 32'h0000DEAD);
    issue(32'h00654020, 32'h10C, mk(32'h10C, 32'hDEAD, 32'h1234, 32'h0, 5'd8, 4'd0, F_RW));
    step();
    wb(1'b0, 5'd0, 32'h0);
    // lw r2,0(r1) then dependent add r4,r2,r2
    issue(32'h8C220000, 32'h110, mk(32'h110, 32'h0, 32'h0, 32'h0, 5'd2, 4'd0, F_RW | F_MR));
    step();
    issue(32'h00422020, 32'h114, mk(32'h114, 32'h0, 32'h0, 32'h0, 5'd4, 4'd0, F_RW));
    #1;
    check("hazard_ir_ready", {143'h0, ir_ready}, '0);
    step();
    check("bubble_dec_valid", {143'h0, dec_valid}, '0);
    check("after_bubble_ir_ready", {143'h0, ir_ready}, {143'h0, 1'b1});
    step();
    // sw r6,4(r5) then stall three cycles with a write to r5 in flight
    issue(32'hACA60004, 32'h118, mk(32'h118, 32'h1234, 32'hFFFF0000, 32'h4, 5'd0, 4'd0, F_MW));
    step();
    ir = 32'h34018000; ir_pc = 32'h11C; ir_valid = 1'b1;
    stall = 1'b1;
    wb(1'b1, 5'd5, 32'h00005555);
    #1;
    check("stall_ir_ready", {143'h0, ir_ready}, '0);
    step();
    wb(1'b0, 5'd0, 32'h0);
    step();
    step();
    flush = 1'b1;
    step();
    check("flush_with_stall_valid", {143'h0, dec_valid}, '0);
    stall = 1'b0; flush = 1'b0;
    // jal, illegal, srl, beq, add r0
    issue(32'h0C000100, 32'h40000010, mk(32'h40000010, 32'h0, 32'h0, 32'h40000400, 5'd31, 4'd0, F_RW | F_JMP));
    step();
    issue(32'hFC000000, 32'h40000014, mk(32'h40000014, 32'h0, 32'h0, 32'h0, 5'd0, 4'd0, F_ILL));
    step();
    issue(32'h00064902, 32'h40000018, mk(32'h40000018, 32'h0, 32'hFFFF0000, 32'h4, 5'd9, 4'd6, F_RW));
    step();
    issue(32'h10A6FFFE, 32'h4000001C, mk(32'h4000001C, 32'h5555, 32'hFFFF0000, 32'hFFFFFFFE, 5'd0, 4'd1, F_BEQ));
    step();
    issue(32'h00A50020, 32'h40000020, mk(32'h40000020, 32'h5555, 32'h5555, 32'h0, 5'd0, 4'd0, 7'b0));
    step();
    ir_valid = 1'b0;
    step();
    check("idle_dec_valid", {143'h0, dec_valid}, '0);
    // reset in the middle of a stream discards the held instruction and clears registers
    issue(32'h00A63820, 32'h180, mk(32'h180, 32'h5555, 32'hFFFF0000, 32'h0, 5'd7, 4'd0, F_RW));
    step();
    ir = 32'h00A63820; ir_pc = 32'h184;
    reset = 1'b1;
    step();
    check("midreset_dec_valid", {143'h0, dec_valid}, '0);
    reset = 1'b0;
    issue(32'h00A63820, 32'h200, mk(32'h200, 32'h0, 32'h0, 32'h0, 5'd7, 4'd0, F_RW));
    step();
    ir_valid = 1'b0;
    step();
    step();
    @(negedge clk);
    #1;
    check("scoreboard_drained", {112'h0, 32'(exp_q.size())}, '0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
